raw_udp_ip_eth_bypass_rx_tx_for_xdma: RTL and testbench



---
 rtl/raw_udp_ip_eth_bypass_rx_tx_for_xdma.sv | 187 ++++++++++++++++++
 tb/tb_raw_udp_ip_eth_bypass_rx_tx_for_xdma.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/raw_udp_ip_eth_bypass_rx_tx_for_xdma.sv
// Raw UDP/IPv4/Ethernet bypass between XDMA and CMAC 512-bit AXI-Stream ports.
// TX forwards host frames unchanged; RX keeps only well-formed IPv4/UDP frames.
`default_nettype none

module raw_udp_bypass_fifo2 #(
   parameter int WIDTH = 578
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   output logic             ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready
);
   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;
   logic [1:0]       count_nxt;
   logic             pop;

   assign pop       = out_valid & out_ready;
   assign out_valid = (count != 2'd0);
   assign out_data  = mem[rd_ptr];

   always_comb begin
      count_nxt = count + {1'b0, push} - {1'b0, pop};
   end

   // ready is registered from the next occupancy so it never sees out_ready combinationally
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
         ready  <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count_nxt;
         ready <= (count_nxt != 2'd2);
      end
   end
endmodule

module raw_udp_ip_eth_bypass_rx_tx_for_xdma (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         xdmaAxiStreamTxIn_tvalid,
   input  logic         xdmaAxiStreamTxIn_tlast,
   input  logic         xdmaAxiStreamTxIn_tuser,
   input  logic [511:0] xdmaAxiStreamTxIn_tdata,
   input  logic [63:0]  xdmaAxiStreamTxIn_tkeep,
   output logic         xdmaAxiStreamTxIn_tready,
   output logic         cmacAxiStreamTxOut_tvalid,
   output logic         cmacAxiStreamTxOut_tlast,
   output logic         cmacAxiStreamTxOut_tuser,
   output logic [511:0] cmacAxiStreamTxOut_tdata,
   output logic [63:0]  cmacAxiStreamTxOut_tkeep,
   input  logic         cmacAxiStreamTxOut_tready,
   input  logic         cmacAxiStreamRxIn_tvalid,
   input  logic         cmacAxiStreamRxIn_tlast,
   input  logic         cmacAxiStreamRxIn_tuser,
   input  logic [511:0] cmacAxiStreamRxIn_tdata,
   input  logic [63:0]  cmacAxiStreamRxIn_tkeep,
   output logic         cmacAxiStreamRxIn_tready,
   output logic         xdmaAxiStreamRxOut_tvalid,
   output logic         xdmaAxiStreamRxOut_tlast,
   output logic         xdmaAxiStreamRxOut_tuser,
   output logic [511:0] xdmaAxiStreamRxOut_tdata,
   output logic [63:0]  xdmaAxiStreamRxOut_tkeep,
   input  logic         xdmaAxiStreamRxOut_tready
);
   typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

   state_t       state;
   state_t       state_nxt;
   logic         tx_push;
   logic         rx_push;
   logic         rx_accept;
   logic         hdr_ok;
   logic [19:0]  csum_sum;
   logic [16:0]  csum_fold1;
   logic [15:0]  csum_fold2;
   logic [577:0] tx_out_beat;
   logic [577:0] rx_out_beat;

   assign tx_push = xdmaAxiStreamTxIn_tvalid & xdmaAxiStreamTxIn_tready;

   raw_udp_bypass_fifo2 #(.WIDTH(578)) u_tx_fifo (
      .clk       (CLK),
      .rst_n     (RST_N),
      .push      (tx_push),
      .wdata     ({xdmaAxiStreamTxIn_tuser, xdmaAxiStreamTxIn_tlast,
                   xdmaAxiStreamTxIn_tkeep, xdmaAxiStreamTxIn_tdata}),
      .ready     (xdmaAxiStreamTxIn_tready),
      .out_valid (cmacAxiStreamTxOut_tvalid),
      .out_data  (tx_out_beat),
      .out_ready (cmacAxiStreamTxOut_tready)
   );

   assign {cmacAxiStreamTxOut_tuser, cmacAxiStreamTxOut_tlast,
           cmacAxiStreamTxOut_tkeep, cmacAxiStreamTxOut_tdata} = tx_out_beat;

   // IPv4 header checksum over bytes 14..33, big-endian words, end-around carry folded twice
   always_comb begin
      csum_sum = '0;
      for (int k = 0; k < 10; k++) begin
         csum_sum = csum_sum + {4'b0, cmacAxiStreamRxIn_tdata[8*(14+2*k) +: 8],
                                      cmacAxiStreamRxIn_tdata[8*(15+2*k) +: 8]};
      end
      csum_fold1 = {1'b0, csum_sum[15:0]} + {13'b0, csum_sum[19:16]};
      csum_fold2 = csum_fold1[15:0] + {15'b0, csum_fold1[16]};
   end

   assign hdr_ok = (&cmacAxiStreamRxIn_tkeep[41:0])
                && (cmacAxiStreamRxIn_tdata[8*12 +: 8] == 8'h08)
                && (cmacAxiStreamRxIn_tdata[8*13 +: 8] == 8'h00)
                && (cmacAxiStreamRxIn_tdata[8*14 +: 8] == 8'h45)
                && (cmacAxiStreamRxIn_tdata[8*23 +: 8] == 8'h11)
                && (csum_fold2 == 16'hFFFF);

   assign rx_accept = cmacAxiStreamRxIn_tvalid & cmacAxiStreamRxIn_tready;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      rx_push   = 1'b0;
      case (state)
         IDLE: begin
            if (rx_accept) begin
               rx_push = hdr_ok;
               if (!cmacAxiStreamRxIn_tlast) begin
                  state_nxt = hdr_ok ? PASS : DROP;
               end
            end
         end
         PASS: begin
            if (rx_accept) begin
               rx_push = 1'b1;
               if (cmacAxiStreamRxIn_tlast) begin
                  state_nxt = IDLE;
               end
            end
         end
         DROP: begin
            if (rx_accept && cmacAxiStreamRxIn_tlast) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   raw_udp_bypass_fifo2 #(.WIDTH(578)) u_rx_fifo (
      .clk       (CLK),
      .rst_n     (RST_N),
      .push      (rx_push),
      .wdata     ({cmacAxiStreamRxIn_tuser, cmacAxiStreamRxIn_tlast,
                   cmacAxiStreamRxIn_tkeep, cmacAxiStreamRxIn_tdata}),
      .ready     (cmacAxiStreamRxIn_tready),
      .out_valid (xdmaAxiStreamRxOut_tvalid),
      .out_data  (rx_out_beat),
      .out_ready (xdmaAxiStreamRxOut_tready)
   );

   assign {xdmaAxiStreamRxOut_tuser, xdmaAxiStreamRxOut_tlast,
           xdmaAxiStreamRxOut_tkeep, xdmaAxiStreamRxOut_tdata} = rx_out_beat;
endmodule

`default_nettype wire

// File: tb/tb_raw_udp_ip_eth_bypass_rx_tx_for_xdma.sv
// Loopback bench: CMAC TX tied to CMAC RX; scoreboards on both output streams.
`default_nettype none

module tb_raw_udp_ip_eth_bypass_rx_tx_for_xdma;
   typedef logic [577:0] beat_t;

   logic         CLK = 1'b0;
   logic         RST_N = 1'b0;
   logic         xt_valid, xt_last, xt_user, xt_ready;
   logic [511:0] xt_data;
   logic [63:0]  xt_keep;
   logic         c_valid, c_last, c_user, c_ready;
   logic [511:0] c_data;
   logic [63:0]  c_keep;
   logic         xr_valid, xr_last, xr_user, xr_ready;
   logic [511:0] xr_data;
   logic [63:0]  xr_keep;

   int    vectors = 0;
   int    miscompares = 0;
   beat_t tx_q[$];
   beat_t rx_q[$];
   beat_t fr_q[$];
   int    rdy_mode = 0;
   bit    watch_rdy = 0;
   bit    stalled = 0;
   beat_t held;

   always #5 CLK = ~CLK;

   raw_udp_ip_eth_bypass_rx_tx_for_xdma dut (
      .CLK                       (CLK),
      .RST_N                     (RST_N),
      .xdmaAxiStreamTxIn_tvalid  (xt_valid),
      .xdmaAxiStreamTxIn_tlast   (xt_last),
      .xdmaAxiStreamTxIn_tuser   (xt_user),
      .xdmaAxiStreamTxIn_tdata   (xt_data),
      .xdmaAxiStreamTxIn_tkeep   (xt_keep),
      .xdmaAxiStreamTxIn_tready  (xt_ready),
      .cmacAxiStreamTxOut_tvalid (c_valid),
      .cmacAxiStreamTxOut_tlast  (c_last),
      .cmacAxiStreamTxOut_tuser  (c_user),
      .cmacAxiStreamTxOut_tdata  (c_data),
      .cmacAxiStreamTxOut_tkeep  (c_keep),
      .cmacAxiStreamTxOut_tready (c_ready),
      .cmacAxiStreamRxIn_tvalid  (c_valid),
      .cmacAxiStreamRxIn_tlast   (c_last),
      .cmacAxiStreamRxIn_tuser   (c_user),
      .cmacAxiStreamRxIn_tdata   (c_data),
      .cmacAxiStreamRxIn_tkeep   (c_keep),
      .cmacAxiStreamRxIn_tready  (c_ready),
      .xdmaAxiStreamRxOut_tvalid (xr_valid),
      .xdmaAxiStreamRxOut_tlast  (xr_last),
      .xdmaAxiStreamRxOut_tuser  (xr_user),
      .xdmaAxiStreamRxOut_tdata  (xr_data),
      .xdmaAxiStreamRxOut_tkeep  (xr_keep),
      .xdmaAxiStreamRxOut_tready (xr_ready)
   );

   task automatic check(string tag, beat_t obs, beat_t exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // host-side RX ready: 0 = always, 1 = hold off, 2 = random
   initial begin
      xr_ready = 1'b1;
      forever begin
         @(posedge CLK);
         #1;
         xr_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      end
   end

   // output monitors, sampled on the falling edge before the transferring rising edge
   initial begin
      forever begin
         @(negedge CLK);
         if (!RST_N) begin
            stalled = 0;
         end else begin
            if (c_valid && c_ready) begin
               check("tx_q_nonempty", beat_t'(tx_q.size() != 0), 1);
               if (tx_q.size() != 0) check("tx_beat", {c_user, c_last, c_keep, c_data}, tx_q.pop_front());
            end
            if (stalled) begin
               check("rx_stall_valid", xr_valid, 1);
               check("rx_stall_payload", {xr_user, xr_last, xr_keep, xr_data}, held);
            end
            if (xr_valid && xr_ready) begin
               check("rx_q_nonempty", beat_t'(rx_q.size() != 0), 1);
               if (rx_q.size() != 0) check("rx_beat", {xr_user, xr_last, xr_keep, xr_data}, rx_q.pop_front());
            end
            stalled = xr_valid && !xr_ready;
            held    = {xr_user, xr_last, xr_keep, xr_data};
            if (watch_rdy) check("rx_in_ready_drop", c_ready, 1);
         end
      end
   end

   // kind: 0 valid, 1 ARP, 2 bad checksum, 3 short (40 B), 4 TCP, 5 IP version/IHL 0x46
   task automatic make_frame(int kind, int nbeats, int last_bytes);
      logic [511:0] d;
      logic [63:0]  k;
      int unsigned  s;
      logic [15:0]  cs;
      fr_q.delete();
      for (int b = 0; b < nbeats; b++) begin
         for (int j = 0; j < 16; j++) d[32*j +: 32] = $urandom;
         k = (b == nbeats - 1 && last_bytes < 64) ? ((64'd1 << last_bytes) - 64'd1) : '1;
         if (b == 0) begin
            for (int i = 0; i < 6; i++) d[8*i +: 8] = 8'hFF;
            d[8*12 +: 8] = 8'h08;
            d[8*13 +: 8] = (kind == 1) ? 8'h06 : 8'h00;
            d[8*14 +: 8] = (kind == 5) ? 8'h46 : 8'h45;
            d[8*15 +: 8] = 8'h00;
            d[8*22 +: 8] = 8'h40;
            d[8*23 +: 8] = (kind == 4) ? 8'h06 : 8'h11;
            d[8*24 +: 8] = 8'h00;
            d[8*25 +: 8] = 8'h00;
            s = 0;
            for (int i = 14; i < 34; i += 2) s += {16'h0, d[8*i +: 8], d[8*(i+1) +: 8]};
            while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
            cs = ~s[15:0];
            if (kind == 2) cs = cs + 16'd1;
            d[8*24 +: 8] = cs[15:8];
            d[8*25 +: 8] = cs[7:0];
         end
         fr_q.push_back({1'($urandom_range(0, 1)), (b == nbeats - 1), k, d});
      end
   endtask

   task automatic send_beat(beat_t b, bit to_rx);
      bit ok = 0;
      {xt_user, xt_last, xt_keep, xt_data} = b;
      xt_valid = 1'b1;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge CLK);
         if (xt_ready === 1'b1) ok = 1;
         else begin
            @(posedge CLK);
            #1;
         end
      end
      check("tx_in_accept", ok, 1);
      if (ok) begin
         tx_q.push_back(b);
         if (to_rx) rx_q.push_back(b);
         @(posedge CLK);
         #1;
      end
      xt_valid = 1'b0;
   endtask

   task automatic send_frame(int kind, int nbeats, int last_bytes);
      make_frame(kind, nbeats, last_bytes);
      foreach (fr_q[i]) send_beat(fr_q[i], kind == 0);
   endtask

   task automatic drain();
      for (int i = 0; i < 500 && (tx_q.size() != 0 || rx_q.size() != 0); i++) @(negedge CLK);
      check("drain_tx_q", tx_q.size(), 0);
      check("drain_rx_q", rx_q.size(), 0);
      @(posedge CLK);
      #1;
   endtask

   initial begin
      int kind, nb, lb;
      xt_valid = 0; xt_last = 0; xt_user = 0; xt_data = '0; xt_keep = '0;
      RST_N = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_ready_valid", {xt_ready, c_ready, c_valid, xr_valid}, 0);
      check("rst_rx_payload", {xr_user, xr_last, xr_keep, xr_data}, 0);
      check("rst_tx_payload", {c_user, c_last, c_keep, c_data}, 0);
      RST_N = 1'b1;
      @(posedge CLK);
      #1;
      check("ready_after_rst", {xt_ready, c_ready}, 2'b11);

      // 100-byte loopback frame, latency of two cycles to the host
      make_frame(0, 2, 36);
      check("frame_last_keep", fr_q[1][575:512], 64'h0000_000F_FFFF_FFFF);
      send_beat(fr_q[0], 1);
      check("lat_cmac_valid", c_valid, 1);
      check("lat_rx_not_yet", xr_valid, 0);
      send_beat(fr_q[1], 1);
      check("lat_rx_valid", xr_valid, 1);
      check("lat_rx_beat0", {xr_user, xr_last, xr_keep, xr_data}, fr_q[0]);
      drain();

      watch_rdy = 1;
      send_frame(1, 1, 60);
      send_frame(1, 3, 20);
      repeat (4) @(posedge CLK);
      #1;
      watch_rdy = 0;
      drain();

      send_frame(2, 2, 30);
      send_frame(0, 2, 50);
      drain();
      send_frame(3, 1, 40);
      send_frame(4, 2, 10);
      send_frame(5, 1, 64);
      send_frame(0, 1, 42);
      drain();

      fork
         begin
            repeat (5) @(posedge CLK);
            rdy_mode = 1;
            repeat (10) @(posedge CLK);
            rdy_mode = 2;
         end
      join_none
      for (int f = 0; f < 8; f++) send_frame(0, 2, $urandom_range(1, 64));
      drain();
      rdy_mode = 0;

      for (int f = 0; f < 30; f++) begin
         kind = $urandom_range(0, 5);
         nb   = (kind == 3) ? 1 : $urandom_range(1, 3);
         lb   = (kind == 3) ? 40 : (nb == 1) ? $urandom_range(42, 64) : $urandom_range(1, 64);
         rdy_mode = (f >= 15) ? 2 : 0;
         send_frame(kind, nb, lb);
         repeat ($urandom_range(0, 2)) @(posedge CLK);
         #1;
      end
      drain();
      rdy_mode = 0;

      // mid-frame reset with host stalled
      rdy_mode = 1;
      make_frame(0, 3, 64);
      send_beat(fr_q[0], 0);
      send_beat(fr_q[1], 0);
      RST_N = 1'b0;
      @(posedge CLK);
      #1;
      check("midrst_ready_valid", {xt_ready, c_ready, c_valid, xr_valid}, 0);
      @(posedge CLK);
      #1;
      tx_q.delete();
      rx_q.delete();
      rdy_mode = 0;
      RST_N = 1'b1;
      @(posedge CLK);
      #1;
      check("midrst_rx_empty", xr_valid, 0);
      send_frame(0, 2, 20);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

`default_nettype wire
